// File: rtl/jacobi_sweep_scheduler_if.sv
// Rotation request/completion bus between the sweep scheduler (master)
// and the shared jacobi rotation datapath (slave).
interface jacobi_sweep_scheduler_if #(
    parameter int WIDTH    = 16,
    parameter int N_STOCKS = 4
);
    localparam int IW = (N_STOCKS > 1) ? $clog2(N_STOCKS) : 1;

    logic             rot_valid;
    logic             rot_ready;
    logic [IW-1:0]    rot_i;
    logic [IW-1:0]    rot_j;
    logic             rot_first;
    logic             rot_done;
    logic [WIDTH-1:0] rot_mag;

    modport master (
        output rot_valid, rot_i, rot_j, rot_first,
        input  rot_ready, rot_done, rot_mag
    );

    modport slave (
        input  rot_valid, rot_i, rot_j, rot_first,
        output rot_ready, rot_done, rot_mag
    );
endinterface

// File: rtl/jacobi_sweep_scheduler.sv
// Cyclic-order Jacobi sweep scheduler: issues pivot pairs (i,j) row by row,
// folds the reported pivot magnitudes into a per-sweep maximum and stops on
// convergence (sweep max < tol) or after MAX_SWEEPS sweeps.
// Optional build macro JACOBI_SCHED_STATS_EN adds a saturating rot_count output.
module jacobi_sweep_scheduler #(
    parameter int WIDTH      = 16,
    parameter int N_STOCKS   = 4,
    parameter int MAX_SWEEPS = 8,
    localparam int IW = (N_STOCKS > 1) ? $clog2(N_STOCKS) : 1,
    localparam int SW = $clog2(MAX_SWEEPS + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [WIDTH-1:0]            tol,
    output logic                        busy,
    output logic                        done,
    output logic                        converged,
    output logic [SW-1:0]               sweeps_used,
    jacobi_sweep_scheduler_if.master    rot
`ifdef JACOBI_SCHED_STATS_EN
    ,
    output logic [15:0]                 rot_count
`endif
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, EVAL} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    p_q, p_d, q_q, q_d;
    logic [SW-1:0]    sweep_q, sweep_d;
    logic [SW-1:0]    sweeps_used_q, sweeps_used_d;
    logic [WIDTH-1:0] smax_q, smax_d, tol_q, tol_d;
    logic             first_q, first_d;
    logic             done_q, done_d;
    logic             conv_q, conv_d;
    logic             last_pair;
    logic             start_acc;

    // The final pair of a sweep is (N-2, N-1).
    assign last_pair = (p_q == IW'(N_STOCKS - 2)) && (q_q == IW'(N_STOCKS - 1));
    // A start in the done cycle is still "while busy" and is dropped.
    assign start_acc = (state_q == IDLE) && !done_q && start;

    // Next-state and datapath update for the sweep sequencer.
    always_comb begin
        state_d       = state_q;
        p_d           = p_q;
        q_d           = q_q;
        sweep_d       = sweep_q;
        sweeps_used_d = sweeps_used_q;
        smax_d        = smax_q;
        tol_d         = tol_q;
        first_d       = first_q;
        done_d        = 1'b0;
        conv_d        = conv_q;
        case (state_q)
            IDLE: begin
                if (start_acc) begin
                    tol_d   = tol;
                    p_d     = '0;
                    q_d     = IW'(1);
                    sweep_d = '0;
                    smax_d  = '0;
                    first_d = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (rot.rot_ready) begin
                    first_d = 1'b0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (rot.rot_done) begin
                    if (rot.rot_mag > smax_q) begin
                        smax_d = rot.rot_mag;
                    end
                    if (last_pair) begin
                        // Rewind here so rot_i/rot_j never leave the index range.
                        p_d     = '0;
                        q_d     = IW'(1);
                        state_d = EVAL;
                    end else if (q_q == IW'(N_STOCKS - 1)) begin
                        p_d     = p_q + IW'(1);
                        q_d     = p_q + IW'(2);
                        state_d = ISSUE;
                    end else begin
                        q_d     = q_q + IW'(1);
                        state_d = ISSUE;
                    end
                end
            end
            EVAL: begin
                sweep_d = sweep_q + SW'(1);
                if (smax_q < tol_q) begin
                    done_d        = 1'b1;
                    conv_d        = 1'b1;
                    sweeps_used_d = sweep_d;
                    state_d       = IDLE;
                end else if (sweep_d == SW'(MAX_SWEEPS)) begin
                    done_d        = 1'b1;
                    conv_d        = 1'b0;
                    sweeps_used_d = sweep_d;
                    state_d       = IDLE;
                end else begin
                    smax_d  = '0;
                    state_d = ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            p_q           <= '0;
            q_q           <= IW'(1);
            sweep_q       <= '0;
            sweeps_used_q <= '0;
            smax_q        <= '0;
            tol_q         <= '0;
            first_q       <= 1'b0;
            done_q        <= 1'b0;
            conv_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            p_q           <= p_d;
            q_q           <= q_d;
            sweep_q       <= sweep_d;
            sweeps_used_q <= sweeps_used_d;
            smax_q        <= smax_d;
            tol_q         <= tol_d;
            first_q       <= first_d;
            done_q        <= done_d;
            conv_q        <= conv_d;
        end
    end

    assign busy          = (state_q != IDLE) || done_q;
    assign done          = done_q;
    assign converged     = conv_q;
    assign sweeps_used   = sweeps_used_q;
    assign rot.rot_valid = (state_q == ISSUE);
    assign rot.rot_first = (state_q == ISSUE) && first_q;
    assign rot.rot_i     = p_q;
    assign rot.rot_j     = q_q;

`ifdef JACOBI_SCHED_STATS_EN
    logic [15:0] cnt_q, cnt_d;

    // Saturating count of handshaken rotations since the last accepted start.
    always_comb begin
        cnt_d = cnt_q;
        if (start_acc) begin
            cnt_d = '0;
        end else if ((state_q == ISSUE) && rot.rot_ready && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Rotation counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign rot_count = cnt_q;
`endif
endmodule

// File: tb/tb_jacobi_sweep_scheduler.sv
// Randomized self-checking bench for jacobi_sweep_scheduler with a behavioural
// jacobi-unit responder (fixed latency) and a sweep-level reference model.
module tb_jacobi_sweep_scheduler;
    localparam int W   = 16;
    localparam int N   = 4;
    localparam int MS  = 8;
    localparam int NP  = N * (N - 1) / 2;
    localparam int LAT = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] tol;
    logic         busy, done, converged;
    logic [3:0]   sweeps_used;
`ifdef JACOBI_SCHED_STATS_EN
    logic [15:0]  rot_count;
`endif

    jacobi_sweep_scheduler_if #(.WIDTH(W), .N_STOCKS(N)) rot_if ();

    jacobi_sweep_scheduler #(.WIDTH(W), .N_STOCKS(N), .MAX_SWEEPS(MS)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .tol         (tol),
        .busy        (busy),
        .done        (done),
        .converged   (converged),
        .sweeps_used (sweeps_used),
        .rot         (rot_if)
`ifdef JACOBI_SCHED_STATS_EN
        ,
        .rot_count   (rot_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int mag_tab [64];
    int rec_i[$], rec_j[$], rec_f[$];
    int hs_count, done_idx, lat_cnt, stall_cnt;
    bit stall_en, ready_rand;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Behavioural jacobi unit: accepts requests, answers LAT cycles later.
    initial begin
        rot_if.rot_ready = 1'b0;
        rot_if.rot_done  = 1'b0;
        rot_if.rot_mag   = '0;
        lat_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                lat_cnt = 0;
                rot_if.rot_done  = 1'b0;
                rot_if.rot_ready = 1'b0;
                continue;
            end
            rot_if.rot_done = 1'b0;
            if (lat_cnt > 0) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    rot_if.rot_done = 1'b1;
                    rot_if.rot_mag  = W'(mag_tab[done_idx % 64]);
                    done_idx++;
                end
            end
            if (stall_en && hs_count == 2 && rot_if.rot_valid && stall_cnt < 10) begin
                rot_if.rot_ready = 1'b0;
                stall_cnt++;
                check_val("stall_valid", 32'(rot_if.rot_valid), 1);
                check_val("stall_i", 32'(rot_if.rot_i), 0);
                check_val("stall_j", 32'(rot_if.rot_j), 3);
            end else begin
                rot_if.rot_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (rot_if.rot_valid && rot_if.rot_ready) begin
                rec_i.push_back(int'(rot_if.rot_i));
                rec_j.push_back(int'(rot_if.rot_j));
                rec_f.push_back(int'(rot_if.rot_first));
                hs_count++;
                lat_cnt = LAT;
            end
        end
    end

    // mode 0: all 5; 1: 100 for two sweeps then 3; 2: all 50;
    // 3: random per-sweep scale around tol; 4: one mag == tol in sweep 1, then tol-1.
    task automatic fill_mags(input int mode, input int tolv);
        for (int k = 0; k < 64; k++) begin
            case (mode)
                0: mag_tab[k] = 5;
                1: mag_tab[k] = (k < 2 * NP) ? 100 : 3;
                2: mag_tab[k] = 50;
                4: mag_tab[k] = (k < NP) ? ((k == 3) ? tolv : 5) : tolv - 1;
                default: mag_tab[k] = 0;
            endcase
        end
        if (mode == 3) begin
            for (int s = 0; s < MS; s++) begin
                int lim;
                lim = ($urandom_range(0, 2) == 0) ? ((tolv > 0) ? tolv - 1 : 0) : 3 * tolv;
                for (int r = 0; r < NP; r++) begin
                    mag_tab[s * NP + r] = $urandom_range(0, lim);
                end
            end
        end
    endtask

    task automatic run_case(input string name, input int tolv, input int mode,
                            input bit rnd, input bit stall, input bit dup);
        int exp_sw, exp_conv, m, got, k;
        int ep_i[$], ep_j[$];
        fill_mags(mode, tolv);
        // Reference: per-sweep max over the rotation magnitudes.
        exp_sw = 0;
        exp_conv = 0;
        for (int s = 0; s < MS; s++) begin
            m = 0;
            for (int r = 0; r < NP; r++) m = (mag_tab[s * NP + r] > m) ? mag_tab[s * NP + r] : m;
            exp_sw = s + 1;
            if (m < tolv) begin
                exp_conv = 1;
                break;
            end
        end
        for (int s = 0; s < exp_sw; s++)
            for (int p = 0; p < N - 1; p++)
                for (int q = p + 1; q < N; q++) begin
                    ep_i.push_back(p);
                    ep_j.push_back(q);
                end

        rec_i.delete(); rec_j.delete(); rec_f.delete();
        hs_count = 0; done_idx = 0; stall_cnt = 0;
        stall_en = stall; ready_rand = rnd;

        @(negedge clk);
        tol = W'(tolv);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val({name, "_first_valid"}, 32'(rot_if.rot_valid), 1);
        check_val({name, "_first_flag"}, 32'(rot_if.rot_first), 1);
        check_val({name, "_busy"}, 32'(busy), 1);

        got = 0;
        for (int c = 0; c < 4000; c++) begin
            if (done) begin
                got = 1;
                break;
            end
            @(negedge clk);
            if (dup && c == 15) begin
                start = 1'b1;
                tol = '0;
            end
            if (dup && c == 16) start = 1'b0;
        end
        start = 1'b0;
        check_val({name, "_done_seen"}, 32'(got), 1);
        check_val({name, "_busy_at_done"}, 32'(busy), 1);
        check_val({name, "_converged"}, 32'(converged), 32'(exp_conv));
        check_val({name, "_sweeps"}, 32'(sweeps_used), 32'(exp_sw));
        check_val({name, "_rotations"}, 32'(hs_count), 32'(exp_sw * NP));
`ifdef JACOBI_SCHED_STATS_EN
        check_val({name, "_rot_count"}, 32'(rot_count), 32'(exp_sw * NP));
`endif
        k = (rec_i.size() < ep_i.size()) ? rec_i.size() : ep_i.size();
        for (int e = 0; e < k; e++) begin
            check_val({name, "_pair"}, 32'(rec_i[e] * 100 + rec_j[e] * 10 + rec_f[e]),
                      32'(ep_i[e] * 100 + ep_j[e] * 10 + ((e == 0) ? 1 : 0)));
        end
        if (stall) check_val({name, "_stall_cycles"}, 32'(stall_cnt), 10);
        @(negedge clk);
        check_val({name, "_done_pulse"}, 32'(done), 0);
        check_val({name, "_idle_busy"}, 32'(busy), 0);
        check_val({name, "_sweeps_held"}, 32'(sweeps_used), 32'(exp_sw));
        $display("run %s tol=%0d sweeps=%0d conv=%0d rotations=%0d", name, tolv,
                 sweeps_used, converged, hs_count);
        stall_en = 1'b0;
    endtask

    task automatic check_reset_vals(input string name);
        check_val({name, "_busy"}, 32'(busy), 0);
        check_val({name, "_done"}, 32'(done), 0);
        check_val({name, "_conv"}, 32'(converged), 0);
        check_val({name, "_sweeps"}, 32'(sweeps_used), 0);
        check_val({name, "_valid"}, 32'(rot_if.rot_valid), 0);
        check_val({name, "_first"}, 32'(rot_if.rot_first), 0);
        check_val({name, "_i"}, 32'(rot_if.rot_i), 0);
        check_val({name, "_j"}, 32'(rot_if.rot_j), 1);
`ifdef JACOBI_SCHED_STATS_EN
        check_val({name, "_rot_count"}, 32'(rot_count), 0);
`endif
    endtask

    initial begin
        int seen, c;
        rst = 1'b1; start = 1'b0; tol = '0;
        stall_en = 1'b0; ready_rand = 1'b0;
        hs_count = 0; done_idx = 0; stall_cnt = 0;
        fill_mags(0, 0);
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;

        run_case("basic", 16, 0, 1'b0, 1'b0, 1'b0);
        run_case("three", 16, 1, 1'b0, 1'b0, 1'b0);
        run_case("tol0", 0, 3, 1'b0, 1'b0, 1'b0);
        run_case("stall", 16, 0, 1'b0, 1'b1, 1'b0);
        run_case("eqtol", 16, 4, 1'b0, 1'b0, 1'b0);

        // Reset in the WAIT of sweep 2.
        fill_mags(2, 0);
        rec_i.delete(); rec_j.delete(); rec_f.delete();
        hs_count = 0; done_idx = 0; ready_rand = 1'b0;
        @(negedge clk);
        tol = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (hs_count < NP + 2 && c < 1000) begin
            @(negedge clk);
            c++;
        end
        check_val("midrst_reached", 32'(hs_count >= NP + 2), 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_vals("midrst");
        rst = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check_val("midrst_quiet", 32'(seen), 0);
        $display("run midrst handshakes_before_reset=%0d", hs_count);

        run_case("restart", 16, 1, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 6; r++) begin
            run_case("rand", $urandom_range(1, 200), 3, 1'b1, 1'b0, (r == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
